// File: rtl/ser_pkg.sv
// ser_pkg: shared constants for the serial transmit arbiter and its helpers.
package ser_pkg;
  localparam int CHAR_W = 8;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_LOW  = 2'd2;
  localparam logic [1:0] S_WAIT_HIGH = 2'd3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] winner_o
);
  always_comb begin
    found_o  = |valid_i;
    winner_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (valid_i[(int'(ptr_i) + i) % N]) winner_o = W'((int'(ptr_i) + i) % N);
  end
endmodule

// File: rtl/ser_xmt_arb.sv
// ser_xmt_arb: round-robin arbiter sharing one serial transmitter among NREQ requesters.
// Defining SER_ARB_LOCK_EN adds req_last so multi-byte messages are sent contiguously.
module ser_xmt_arb import ser_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CHAR_W-1:0]   req_data,
`ifdef SER_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_last,
`endif
  output logic [NREQ-1:0]          req_ack,
  output logic                     xmt_start,
  output logic [CHAR_W-1:0]        xmt_data,
  input  logic                     xmt_rdy,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);
  logic [1:0]        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, gid_q, gid_d, winner, ptr_nxt;
  logic [CHAR_W-1:0] data_q, data_d;
  logic [NREQ-1:0]   ack_q, ack_d, cand;
  logic              start_q, start_d, busy_q, busy_d, found, grant;
`ifdef SER_ARB_LOCK_EN
  logic              lock_q, lock_d;
  // while locked only the last granted requester may win, even if it drops valid
  assign cand = lock_q ? req_valid & (NREQ'(1) << gid_q) : req_valid;
`else
  assign cand = req_valid;
`endif
  rr_pick #(.N(NREQ), .W(IDW)) u_pick (
    .valid_i (cand),
    .ptr_i   (ptr_q),
    .found_o (found),
    .winner_o(winner)
  );
  assign grant   = state_q == S_IDLE && xmt_rdy && found;
  assign ptr_nxt = winner == IDW'(NREQ - 1) ? '0 : winner + 1'b1;
  always_comb begin
    state_d = grant ? S_START :
              state_q == S_START ? S_WAIT_LOW :
              (state_q == S_WAIT_LOW && !xmt_rdy) ? S_WAIT_HIGH :
              (state_q == S_WAIT_HIGH && xmt_rdy) ? S_IDLE : state_q;
    start_d = grant;
    ack_d   = grant ? NREQ'(1) << winner : '0;
    data_d  = grant ? req_data[winner*CHAR_W +: CHAR_W] : data_q;
    gid_d   = grant ? winner : gid_q;
    busy_d  = state_d != S_IDLE;
`ifdef SER_ARB_LOCK_EN
    ptr_d   = grant && req_last[winner] ? ptr_nxt : ptr_q;
    lock_d  = grant ? !req_last[winner] : lock_q;
`else
    ptr_d   = grant ? ptr_nxt : ptr_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
`ifdef SER_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lock_q <= 1'b0;
    else lock_q <= lock_d;
`endif
  assign req_ack   = ack_q;
  assign xmt_start = start_q;
  assign xmt_data  = data_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;
endmodule

// File: tb/tb_ser_xmt_arb.sv
// tb_ser_xmt_arb: directed plus randomized bench for ser_xmt_arb with a behavioural model and transmitter emulation.
module tb_ser_xmt_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
`ifdef SER_ARB_LOCK_EN
  logic [NREQ-1:0]   req_last = '1;
`endif
  logic              xmt_rdy = 1'b1;
  logic [NREQ-1:0]   req_ack;
  logic              xmt_start, busy;
  logic [7:0]        xmt_data;
  logic [IDW-1:0]    grant_id;

  int n_chk = 0, n_fail = 0;
  int tx_d = 0, tx_n = 0, tx_dmin = 0, tx_dmax = 0, tx_lmin = 2, tx_lmax = 2;
  bit tx_block = 1'b0, rnd_on = 1'b0;
  logic [7:0] log_data[$];
  int         log_gid[$];

  // model: idle / just started / waiting for rdy low / waiting for rdy high
  bit m_idle = 1'b1, m_js = 1'b0, m_nl = 1'b0, m_nh = 1'b0, m_start = 1'b0, m_lock = 1'b0;
  int m_ptr = 0, m_gid = 0, w;
  logic [7:0]      m_data = '0;
  logic [NREQ-1:0] m_ack = '0, cand;

  always #5 clk = ~clk;

  ser_xmt_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
`ifdef SER_ARB_LOCK_EN
    .req_last (req_last),
`endif
    .req_ack  (req_ack),
    .xmt_start(xmt_start),
    .xmt_data (xmt_data),
    .xmt_rdy  (xmt_rdy),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_idle = 1'b1; m_js = 1'b0; m_nl = 1'b0; m_nh = 1'b0; m_start = 1'b0; m_lock = 1'b0;
      m_ptr = 0; m_gid = 0; m_data = '0; m_ack = '0;
    end else begin
      m_start = 1'b0;
      m_ack = '0;
      if (m_idle) begin
        cand = req_valid;
`ifdef SER_ARB_LOCK_EN
        if (m_lock) cand = cand & (NREQ'(1) << m_gid);
`endif
        if (xmt_rdy && cand != '0) begin
          w = pick(cand, m_ptr);
          m_start = 1'b1;
          m_ack = NREQ'(1) << w;
          m_data = req_data[w*8 +: 8];
          m_gid = w;
`ifdef SER_ARB_LOCK_EN
          m_lock = !req_last[w];
          if (req_last[w]) m_ptr = (w + 1) % NREQ;
`else
          m_ptr = (w + 1) % NREQ;
`endif
          m_idle = 1'b0;
          m_js = 1'b1;
        end
      end else if (m_js) begin
        m_js = 1'b0;
        m_nl = 1'b1;
      end else if (m_nl) begin
        if (!xmt_rdy) begin m_nl = 1'b0; m_nh = 1'b1; end
      end else if (m_nh && xmt_rdy) begin
        m_nh = 1'b0;
        m_idle = 1'b1;
      end
    end
    chk("start", 32'(xmt_start), 32'(m_start));
    chk("ack", 32'(req_ack), 32'(m_ack));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    if (m_start || !rst_n) chk("data", 32'(xmt_data), 32'(m_data));
    if (xmt_start) begin
      log_data.push_back(xmt_data);
      log_gid.push_back(int'(grant_id));
    end
  end

  // transmitter: rdy stays high tx_d cycles after a start, then low tx_n cycles
  task automatic tx_update();
    if (xmt_start) begin
      tx_d = $urandom_range(tx_dmax, tx_dmin);
      tx_n = $urandom_range(tx_lmax, tx_lmin);
    end
    if (tx_d > 0) begin tx_d--; xmt_rdy = 1'b1; end
    else if (tx_n > 0) begin tx_n--; xmt_rdy = 1'b0; end
    else xmt_rdy = !tx_block;
  endtask

  task automatic rnd_req();
    for (int k = 0; k < NREQ; k++) begin
      if (req_ack[k]) begin
        if ($urandom_range(0, 1) == 1) begin
          req_data[k*8 +: 8] = 8'($urandom);
`ifdef SER_ARB_LOCK_EN
          req_last[k] = 1'($urandom_range(0, 1));
`endif
        end else req_valid[k] = 1'b0;
      end else if (!req_valid[k]) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid[k] = 1'b1;
          req_data[k*8 +: 8] = 8'($urandom);
`ifdef SER_ARB_LOCK_EN
          req_last[k] = 1'($urandom_range(0, 1));
`endif
        end
      end else if ($urandom_range(0, 60) == 0) req_valid[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tx_update();
    if (rnd_on) begin
      rnd_req();
      if ($urandom_range(0, 40) == 0) tx_block = !tx_block;
    end
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    repeat (200) begin
      if (!busy && tx_d == 0 && tx_n == 0 && xmt_rdy) begin ok = 1'b1; break; end
      tick();
    end
    chk("quiet_timeout", 32'(ok), 1);
  endtask

  task automatic wait_log(input int n);
    repeat (100) begin
      if (log_data.size() >= n) break;
      tick();
    end
    chk("log_len", log_data.size(), n);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] e3d[5];
    int         e3g[5];
    bit         seen;
    e3d = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
    e3g = '{0, 1, 2, 3, 0};
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(xmt_start), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_data", 32'(xmt_data), 0);
    rst_n = 1'b1;
    // reset while a start/ack is in flight
    tick();
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5A;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (xmt_start) begin seen = 1'b1; break; end
    end
    chk("t1_start_seen", 32'(seen), 1);
    chk("t1_ack", 32'(req_ack), 32'h4);
    chk("t1_gid", 32'(grant_id), 2);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("t1_start_cleared", 32'(xmt_start), 0);
    chk("t1_ack_cleared", 32'(req_ack), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_gid_after", 32'(grant_id), 0);
    wait_quiet();
    // single requester, slow transmitter
    log_data.delete(); log_gid.delete();
    tx_dmin = 4; tx_dmax = 4;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h41;
    tick();
    chk("t2_start", 32'(xmt_start), 1);
    chk("t2_data", 32'(xmt_data), 32'h41);
    chk("t2_ack", 32'(req_ack), 32'h1);
    repeat (5) tick();
    chk("t2_no_second_start", log_data.size(), 1);
    repeat (3) tick();
    chk("t2_second_start", log_data.size(), 2);
    if (log_data.size() > 0) chk("t2_log_data", 32'(log_data[0]), 32'h41);
    req_valid = '0;
    tx_dmin = 0; tx_dmax = 0;
    wait_quiet();
    // fairness
    do_reset();
    wait_quiet();
    log_data.delete(); log_gid.delete();
    req_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) req_data[k*8 +: 8] = 8'(8'h30 + k);
    wait_log(5);
    req_valid = '0;
    wait_quiet();
    for (int i = 0; i < 5; i++)
      if (i < log_data.size()) begin
        chk("t3_data", 32'(log_data[i]), 32'(e3d[i]));
        chk("t3_gid", log_gid[i], e3g[i]);
      end
    // blocked transmitter
    tx_block = 1'b1;
    xmt_rdy = 1'b0;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h55;
    repeat (20) begin
      tick();
      chk("t4_start", 32'(xmt_start), 0);
      chk("t4_ack", 32'(req_ack), 0);
      chk("t4_busy", 32'(busy), 0);
    end
    tx_block = 1'b0;
    xmt_rdy = 1'b1;
    tick();
    chk("t4_start_after", 32'(xmt_start), 1);
    chk("t4_ack_after", 32'(req_ack), 32'h2);
    chk("t4_data_after", 32'(xmt_data), 32'h55);
    req_valid = '0;
    wait_quiet();
    // bring ptr to 3, then wrap and skip
    log_data.delete(); log_gid.delete();
    req_valid = 4'b0100;
    req_data[23:16] = 8'h62;
    wait_log(1);
    req_valid = '0;
    wait_quiet();
    if (log_gid.size() > 0) chk("t5_pre_gid", log_gid[0], 2);
    log_data.delete(); log_gid.delete();
    req_valid = 4'b0101;
    req_data[7:0] = 8'h70;
    req_data[23:16] = 8'h72;
    wait_log(2);
    req_valid = '0;
    wait_quiet();
    if (log_gid.size() > 1) begin
      chk("t5_gid0", log_gid[0], 0);
      chk("t5_gid1", log_gid[1], 2);
      chk("t5_data0", 32'(log_data[0]), 32'h70);
      chk("t5_data1", 32'(log_data[1]), 32'h72);
    end
`ifdef SER_ARB_LOCK_EN
    begin
      logic [7:0] e6[4];
      int c0;
      e6 = '{8'hA0, 8'hA1, 8'hA2, 8'hB1};
      c0 = 0;
      do_reset();
      wait_quiet();
      log_data.delete(); log_gid.delete();
      req_last = 4'b0010;
      req_data[7:0] = 8'hA0;
      req_data[15:8] = 8'hB1;
      req_valid = 4'b0011;
      repeat (100) begin
        tick();
        if (req_ack[0]) begin
          c0++;
          if (c0 == 3) req_valid[0] = 1'b0;
          else begin
            req_data[7:0] = 8'(8'hA0 + c0);
            req_last[0] = (c0 == 2);
          end
        end
        if (req_ack[1]) req_valid[1] = 1'b0;
      end
      req_last = '1;
      chk("t6_len", log_data.size(), 4);
      for (int i = 0; i < 4; i++)
        if (i < log_data.size()) chk("t6_data", 32'(log_data[i]), 32'(e6[i]));
      wait_quiet();
    end
`endif
    // randomized traffic with a mid-run reset
    do_reset();
    wait_quiet();
    log_data.delete(); log_gid.delete();
    tx_dmin = 0; tx_dmax = 3; tx_lmin = 1; tx_lmax = 5;
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) rst_n = 1'b0;
      if (i == 1501) rst_n = 1'b1;
    end
    rnd_on = 1'b0;
    tx_block = 1'b0;
    req_valid = '0;
    wait_quiet();
    chk("rnd_activity", 32'(log_data.size() > 50), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ser_xmt_arb.md
Name: ser_xmt_arb

Overview:
- Round-robin arbiter and sequencer that shares one serial transmitter among NREQ requesters.
- Accepts one character per grant from a requester and issues it to the transmitter as a one-cycle start pulse.
- Tracks the transmitter's ready/busy cycle before the next grant.
- Sits between CPU/debug character sources and the transmitter (start/data/rdy interface).

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, grant id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  requester k has a character pending
- req_data  in  NREQ*8  character of requester k in bits [8k+7:8k]
- req_ack  out  NREQ  one-cycle pulse: character of requester k accepted
- xmt_start  out  1  start pulse to transmitter
- xmt_data  out  8  character to transmitter, valid while xmt_start=1
- xmt_rdy  in  1  transmitter idle
- busy  out  1  arbiter not in IDLE
- grant_id  out  IDW  index of the last granted requester

Behaviour:
- All outputs are registered.
- Reset values: req_ack=0, xmt_start=0, xmt_data=0, busy=0, grant_id=0, rr pointer=0, state=IDLE.
- States: IDLE, START, WAIT_LOW, WAIT_HIGH.
- IDLE: if xmt_rdy=1 and any req_valid:
  - Winner is the first valid index scanning ptr, ptr+1, ... mod NREQ.
  - Latch the winner's req_data; grant_id<=winner; ptr<=(winner+1) mod NREQ.
  - Go to START.
  - If xmt_rdy=0, stay in IDLE and grant nothing.
- START (exactly one cycle):
  - xmt_start=1, xmt_data=latched char, req_ack[winner]=1, busy=1.
  - Go to WAIT_LOW.
- WAIT_LOW: hold until xmt_rdy=0, then go to WAIT_HIGH. This blocks a double start while the transmitter has not yet registered the first one.
- WAIT_HIGH: hold until xmt_rdy=1, then go to IDLE.
- Latency:
  - Sample in IDLE at cycle T; start and ack appear at T+1.
  - The next grant happens at the earliest the cycle after rdy returns high.
- Requester rules:
  - Hold req_valid and req_data stable until req_ack.
  - Dropping req_valid before it is granted is legal; the request is simply not seen.
  - Valid may stay high after ack to present the next character; it is re-arbitrated fairly.
- Simultaneous requests: strict round-robin. A requester that keeps valid asserted waits at most NREQ-1 grants.
- Single requester: that requester is granted back to back, one character per transmitter cycle.
- ptr wrap: NREQ-1 -> 0.
- busy=1 in START, WAIT_LOW and WAIT_HIGH.
- Reset mid-operation: return to reset values immediately, including any in-flight ack or start. A character already handed to the transmitter is not tracked. After reset, IDLE waits for xmt_rdy=1.
- Unused req_data bits of non-winners are ignored.

Optional Feature:
- Macro SER_ARB_LOCK_EN.
- Defined:
  - Extra input req_last (NREQ).
  - After a grant whose req_last[winner]=0, the arbiter locks onto that requester. In IDLE only that requester is considered; others wait even if it drops valid.
  - The lock releases after a granted character with req_last=1, or on reset.
  - ptr advances only on release.
  - Use: multi-byte messages stay contiguous.
- Undefined: port absent; every character is arbitrated independently.

Decomposition:
- Shared package ser_pkg:
  - State encoding constants (IDLE=0, START=1, WAIT_LOW=2, WAIT_HIGH=3).
  - Character width constant CHAR_W=8.
- Sub-module rr_pick (combinational): inputs valid vector and ptr; outputs found and winner index. It is reusable by other arbiters.
- Registers and FSM stay in ser_xmt_arb.

Test Plan:
1. Reset: rst_n=0 mid-START -> xmt_start and req_ack go 0 immediately; after release, busy=0 and grant_id=0.
2. Single request: req_valid=0001, data0=0x41, xmt_rdy=1 -> one cycle later xmt_start=1, xmt_data=0x41, req_ack=0001; no second start until xmt_rdy goes 0 then 1.
3. Fairness: req_valid=1111 held, chars 0x30..0x33 -> xmt_data order 0x30,0x31,0x32,0x33,0x30; grant_id 0,1,2,3,0.
4. Blocked transmitter: xmt_rdy=0 with req_valid=0010 for 20 cycles -> no start, no ack, busy=0; xmt_rdy->1 -> start one cycle later.
5. Pointer wrap and skip: ptr=3, req_valid=0101 -> grant 0, then grant 2.
6. SER_ARB_LOCK_EN: req0 sends 3 chars with last=0,0,1 while req1 is valid -> all 3 req0 chars are issued first, then req1.
